display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles per digit slot; SHALL be at least 2.
REQ-002 Parameter BLANK_CYCLES, default 1000, blanked cycles at the start of each slot; SHALL be less than REFRESH_DIV.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  scan enable; 0 blanks the display and parks the scan.
REQ-006 YInput  input  8  ALU result to display; upper nibble is B, lower nibble is A.
REQ-007 operation  input  4  operation number to display.
REQ-008 anode  output  4  active-low digit strobe to the decoder and board, one-cold when driven.
REQ-009 YInput_latched  output  8  frame-stable copy of YInput for the decoder.
REQ-010 operation_latched  output  4  frame-stable copy of operation for the decoder.
REQ-011 digit_sel  output  2  current slot index, 0 to 3.
REQ-012 frame_tick  output  1  one-cycle pulse at each frame wrap.

Function
REQ-013 The block SHALL hold these registers: prescale_cnt, digit_sel, run_q, YInput_latched, operation_latched and frame_tick.
- prescale_cnt: range 0 to REFRESH_DIV-1.
- run_q: registered copy of en.
REQ-014 The block SHALL raise a start event when en=1 and run_q=0.
REQ-015 On a start event, prescale_cnt and digit_sel SHALL be 0 next cycle, and both latched outputs SHALL load the current YInput and operation.
REQ-016 With en=1 and run_q=1, prescale_cnt SHALL increment each cycle and wrap from REFRESH_DIV-1 to 0.
REQ-017 When prescale_cnt wraps, digit_sel SHALL advance modulo 4 (0, 1, 2, 3, 0).
REQ-018 On the advance from 3 to 0, both latched outputs SHALL reload from the inputs, and frame_tick SHALL be 1 for exactly the following cycle.
REQ-019 Outside start events and 3-to-0 wraps, the latched outputs SHALL hold, so values never change mid-frame.
REQ-020 With en=0, prescale_cnt and digit_sel SHALL clear to 0 next cycle, frame_tick SHALL be 0, and the latched outputs SHALL hold.
REQ-021 anode SHALL be decoded only from registered state (digit_sel, prescale_cnt, run_q), with no combinational path from en, YInput or operation.
REQ-022 anode decode SHALL be:
- run_q=0: 4'b1111.
- digit_sel 0: 4'b1110 (operation).
- digit_sel 1: 4'b1101.
- digit_sel 2: 4'b1011 (A).
- digit_sel 3: 4'b0111 (B).
- Blanking per REQ-027 overrides the above.
REQ-023 No more than one anode bit SHALL be 0 in any cycle.
REQ-024 If en falls on the same cycle as a 3-to-0 wrap, the en=0 rule SHALL win: no reload and no frame_tick.

Reset
REQ-025 While reset is high, the registers SHALL take these values asynchronously:
- prescale_cnt=0, digit_sel=0, run_q=0, frame_tick=0.
- YInput_latched=8'h00, operation_latched=4'h0.
- Therefore anode=4'b1111.
REQ-026 On reset release, the first rising edge with en=1 SHALL be a start event (REQ-015); reset asserted mid-frame SHALL abort the frame immediately.

Configuration
REQ-027 With macro DISP_BLANK_EN defined: anode SHALL be 4'b1111 whenever prescale_cnt < BLANK_CYCLES, and this blanking interval SHALL suppress ghosting between digits.
REQ-028 With DISP_BLANK_EN undefined: no blanking, BLANK_CYCLES SHALL be ignored, and anode SHALL follow digit_sel for the whole slot.

Verification (REFRESH_DIV=4, BLANK_CYCLES=1)
REQ-029 Reset test: reset=1 with en=1 and YInput=8'hA5 -> anode=1111, latched outputs 0, frame_tick=0 throughout reset.
REQ-030 Scan test: release reset, en=1 -> digit_sel steps 0,1,2,3 every 4 cycles, anode follows 1110, 1101, 1011, 0111, and frame_tick pulses once every 16 cycles.
REQ-031 Frame-stability test: YInput=8'h3C at start, change to 8'hF0 in slot 1 -> YInput_latched stays 8'h3C until the wrap, then becomes 8'hF0.
REQ-032 Enable-drop test: drop en in slot 2, cycle 1 -> next cycle anode=1111 and digit_sel=0; reassert en with operation=4'h7 -> operation_latched=4'h7 and slot 0 restarts.
REQ-033 Blanking test: with DISP_BLANK_EN defined -> anode=1111 at prescale_cnt 0 of every slot and one-cold at cycles 1 to 3; with it undefined, one-cold at all 4 cycles.
REQ-034 Collision test: deassert en on the exact 3-to-0 wrap cycle -> no frame_tick, latched outputs unchanged.

Source files
------------

// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: enable, display inputs and frame-stable outputs of the scan controller
interface display_scan_ctrl_if;
  logic       en;
  logic [7:0] YInput;
  logic [3:0] operation;
  logic [3:0] anode;
  logic [7:0] YInput_latched;
  logic [3:0] operation_latched;
  logic [1:0] digit_sel;
  logic       frame_tick;
  modport master (
    output en, YInput, operation,
    input  anode, YInput_latched, operation_latched, digit_sel, frame_tick
  );
  modport slave (
    input  en, YInput, operation,
    output anode, YInput_latched, operation_latched, digit_sel, frame_tick
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit multiplexed display scanner with per-frame input latching
// Optional DISP_BLANK_EN blanks the first BLANK_CYCLES of every slot to suppress ghosting.
module display_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic clk,
  input logic reset,
  display_scan_ctrl_if.slave bus
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  logic [CW-1:0] prescale_cnt;
  logic [1:0]    digit_sel;
  logic          run_q;
  logic [7:0]    YInput_latched;
  logic [3:0]    operation_latched;
  logic          frame_tick;
  logic          last;
  logic          blank;
  logic [3:0]    anode;
  assign last = prescale_cnt == LAST;
`ifdef DISP_BLANK_EN
  localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);
  assign blank = prescale_cnt < BLANK;
`else
  assign blank = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      prescale_cnt      <= '0;
      digit_sel         <= '0;
      run_q             <= 1'b0;
      frame_tick        <= 1'b0;
      YInput_latched    <= 8'h00;
      operation_latched <= 4'h0;
    end else begin
      run_q      <= bus.en;
      frame_tick <= 1'b0;
      if (!bus.en || !run_q) begin
        prescale_cnt <= '0;
        digit_sel    <= '0;
        if (bus.en) begin
          YInput_latched    <= bus.YInput;
          operation_latched <= bus.operation;
        end
      end else begin
        prescale_cnt <= last ? '0 : prescale_cnt + 1'b1;
        if (last) digit_sel <= digit_sel + 1'b1;
        // frame boundary: refresh the displayed values only here so a frame never tears
        if (last && digit_sel == 2'd3) begin
          YInput_latched    <= bus.YInput;
          operation_latched <= bus.operation;
          frame_tick        <= 1'b1;
        end
      end
    end
  always_comb anode = (!run_q || blank) ? 4'b1111 : ~(4'b0001 << digit_sel);
  assign bus.anode             = anode;
  assign bus.digit_sel         = digit_sel;
  assign bus.YInput_latched    = YInput_latched;
  assign bus.operation_latched = operation_latched;
  assign bus.frame_tick        = frame_tick;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench for display_scan_ctrl with REFRESH_DIV=4, BLANK_CYCLES=1
module tb_display_scan_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  display_scan_ctrl_if bus ();
  display_scan_ctrl #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    string      name;
    logic [3:0] an;
    logic [1:0] sel;
    logic [7:0] yl;
    logic [3:0] ol;
    logic       ft;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  function automatic logic [3:0] exp_an(input int sel, input int cnt);
    logic [3:0] r;
    case (sel)
      0: r = 4'b1110;
      1: r = 4'b1101;
      2: r = 4'b1011;
      default: r = 4'b0111;
    endcase
`ifdef DISP_BLANK_EN
    if (cnt == 0) r = 4'b1111;
`else
    if (cnt < 0) r = 4'b1111;
`endif
    return r;
  endfunction
  task automatic step(input logic r, input logic e, input logic [7:0] y, input logic [3:0] op,
                      input logic [3:0] an, input logic [1:0] sel, input logic [7:0] yl,
                      input logic [3:0] ol, input logic ft, input string nm);
    exp_t x;
    @(negedge clk);
    reset = r;
    bus.en = e;
    bus.YInput = y;
    bus.operation = op;
    x.name = nm;
    x.an = an;
    x.sel = sel;
    x.yl = yl;
    x.ol = ol;
    x.ft = ft;
    q.push_back(x);
  endtask
  task automatic run(input int k, input logic [7:0] y, input logic [3:0] op,
                     input logic [7:0] yl, input logic [3:0] ol, input string nm);
    step(1'b0, 1'b1, y, op, exp_an((k / 4) % 4, k % 4), 2'((k / 4) % 4), yl, ol,
         k > 0 && k % 16 == 0, nm);
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t x;
        x = q.pop_front();
        checks++;
        if (bus.anode !== x.an || bus.digit_sel !== x.sel || bus.YInput_latched !== x.yl ||
            bus.operation_latched !== x.ol || bus.frame_tick !== x.ft) begin
          errors++;
          $display("FAIL %s: got an=%b sel=%0d yl=%h ol=%h ft=%b, want an=%b sel=%0d yl=%h ol=%h ft=%b",
                   x.name, bus.anode, bus.digit_sel, bus.YInput_latched, bus.operation_latched,
                   bus.frame_tick, x.an, x.sel, x.yl, x.ol, x.ft);
        end
      end
    end
  end
  initial begin
    bus.en = 1'b1;
    bus.YInput = 8'hA5;
    bus.operation = 4'h3;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'hA5, 4'h3, 4'b1111, 2'd0, 8'h00, 4'h0, 1'b0, "reset");
    for (int k = 0; k <= 32; k++)
      run(k, (k >= 5) ? 8'hF0 : 8'h3C, 4'h5, (k < 16) ? 8'h3C : 8'hF0, 4'h5, (k == 0) ? "start" : "scan");
    for (int k = 33; k <= 41; k++) run(k, 8'hF0, 4'h5, 8'hF0, 4'h5, "pre_drop");
    step(1'b0, 1'b0, 8'hF0, 4'h5, 4'b1111, 2'd0, 8'hF0, 4'h5, 1'b0, "en_drop");
    step(1'b0, 1'b0, 8'h12, 4'h7, 4'b1111, 2'd0, 8'hF0, 4'h5, 1'b0, "parked");
    for (int k = 0; k <= 15; k++)
      run(k, (k < 10) ? 8'h12 : 8'h99, (k < 10) ? 4'h7 : 4'h9, 8'h12, 4'h7, "restart");
    step(1'b0, 1'b0, 8'h99, 4'h9, 4'b1111, 2'd0, 8'h12, 4'h7, 1'b0, "collision");
    step(1'b0, 1'b0, 8'h99, 4'h9, 4'b1111, 2'd0, 8'h12, 4'h7, 1'b0, "collision_hold");
    for (int k = 0; k <= 5; k++) run(k, 8'h44, 4'h2, 8'h44, 4'h2, "rerun");
    step(1'b1, 1'b1, 8'h44, 4'h2, 4'b1111, 2'd0, 8'h00, 4'h0, 1'b0, "mid_reset");
    for (int k = 0; k <= 2; k++) run(k, 8'h66, 4'h1, 8'h66, 4'h1, "post_reset");
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
